// File: rtl/cpu_dbg_pkg.sv
// ============================================================================
// Module      : cpu_dbg_pkg
// Description : Shared types and codes for the CPU run/single-step controller:
//               controller state encoding and stop-cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_dbg_pkg;

    // Controller states; two bits cover all four.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Reason the last burst or run ended, as reported on stop_cause.
    localparam logic [1:0] CAUSE_USER = 2'd0;
    localparam logic [1:0] CAUSE_STEP = 2'd1;
    localparam logic [1:0] CAUSE_HALT = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

endpackage : cpu_dbg_pkg

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Run/single-step controller gating CPU execution through a
//               clock-enable. Converts a run level or a counted step request
//               into enabled CPU cycles, stops on HALT or a PC breakpoint,
//               and reports the stop cause plus a running enabled-cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              run_req,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic              halt_instr,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic [1:0]        stop_cause,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    state_e              state_q,     state_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic                first_q,     first_d;
    logic [1:0]          cause_q,     cause_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic                stop_halt;
    logic                stop_bp;

    // Stop detection: HALT always wins; the breakpoint is masked on the first
    // cycle after a start so execution can resume from a breakpointed PC.
    always_comb begin
        stop_halt = halt_instr;
        stop_bp   = bp_en && (pc == bp_addr) && !first_q;
    end

    // Next-state, step bookkeeping and Mealy enable generation.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        cause_d     = cause_q;
        cpu_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (step_req) begin
                    state_d     = ST_STEP;
                    remaining_d = (step_count == {STEP_W{1'b0}}) ? STEP_ONE : step_count;
                    first_d     = 1'b1;
                end else if (run_req) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end
            end

            ST_STEP: begin
                busy    = 1'b1;
                first_d = 1'b0;
                if (stop_halt) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (stop_bp) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_BP;
                end else begin
                    cpu_en      = 1'b1;
                    remaining_d = remaining_q - STEP_ONE;
                    if (remaining_q == STEP_ONE) begin
                        state_d = ST_DONE;
                        cause_d = CAUSE_STEP;
                    end
                end
            end

            ST_RUN: begin
                busy    = 1'b1;
                first_d = 1'b0;
                if (stop_halt) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (stop_bp) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_BP;
                end else if (run_req) begin
                    cpu_en = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_USER;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired-cycle counter: counts every enabled cycle, wrapping naturally.
    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, cpu_en};
    end

    // State register with asynchronous reset so a burst is abandoned at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= {STEP_W{1'b0}};
            first_q     <= 1'b0;
            cause_q     <= CAUSE_USER;
            cnt_q       <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stop_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule : cpu_step_ctrl

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module      : tb_cpu_step_ctrl
// Description : Scoreboard bench for cpu_step_ctrl. Each burst's outcome is
//               predicted from the stop rules and queued; a monitor compares
//               it against what the DUT shows when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_ctrl;
    import cpu_dbg_pkg::*;

    localparam int PC_W   = 32;
    localparam int CNT_W  = 32;
    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              step_req = 1'b0;
    logic [STEP_W-1:0] step_count = '0;
    logic              run_req = 1'b0;
    logic              bp_en = 1'b0;
    logic [PC_W-1:0]   bp_addr = '0;
    logic [PC_W-1:0]   pc = '0;
    logic              halt_instr = 1'b0;
    logic              cpu_en;
    logic              busy;
    logic              done;
    logic [1:0]        stop_cause;
    logic [CNT_W-1:0]  cycle_cnt;

    cpu_step_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_req   (step_req),
        .step_count (step_count),
        .run_req    (run_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .halt_instr (halt_instr),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .done       (done),
        .stop_cause (stop_cause),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          en;
        int          busy_cyc;
        logic [1:0]  cause;
        logic [31:0] total;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_total = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Predict one burst from the stop rules and drive it cycle by cycle.
    // Index i is the i-th cycle spent in STEP/RUN after the request cycle.
    task automatic burst(input bit is_step, input int n, input int halt_at,
                         input int bp_at, input bit bpen, input logic [31:0] bpa);
        int   neff, last, s, en;
        bit   h_ok, b_ok;
        logic [1:0] cause;
        exp_t e;
        neff = is_step ? ((n == 0) ? 1 : n) : n;
        last = is_step ? neff - 1 : n;
        h_ok = (halt_at >= 0) && (halt_at <= last);
        b_ok = bpen && (bp_at >= 1) && (bp_at <= last);
        if (h_ok && (!b_ok || halt_at <= bp_at)) begin
            s = halt_at; en = halt_at; cause = CAUSE_HALT;
        end else if (b_ok) begin
            s = bp_at;   en = bp_at;   cause = CAUSE_BP;
        end else begin
            s = last;    en = neff;    cause = is_step ? CAUSE_STEP : CAUSE_USER;
        end
        exp_total  = exp_total + 32'(en);
        e.en       = en;
        e.busy_cyc = s + 1;
        e.cause    = cause;
        e.total    = exp_total;
        sb.push_back(e);

        // request cycle
        @(posedge clk); #1;
        bp_en      = bpen;
        bp_addr    = bpa;
        halt_instr = 1'b0;
        pc         = bpa + 32'h100;
        if (is_step) begin
            step_req   = 1'b1;
            step_count = STEP_W'(n);
            run_req    = 1'($urandom_range(0, 1));
        end else begin
            step_req   = 1'b0;
            step_count = STEP_W'($urandom);
            run_req    = 1'b1;
        end
        // active cycles
        for (int i = 0; i <= s; i++) begin
            @(posedge clk); #1;
            step_req   = is_step ? 1'b0 : 1'($urandom_range(0, 1));
            run_req    = is_step ? 1'($urandom_range(0, 1)) : (i < n);
            step_count = STEP_W'($urandom);
            halt_instr = (halt_at == i);
            pc         = (bp_at == i) ? bpa : bpa + 32'h100 + 32'(i);
        end
        // DONE cycle: requests here must be ignored
        @(posedge clk); #1;
        halt_instr = 1'b0;
        pc         = bpa + 32'h100;
        step_req   = 1'($urandom_range(0, 1));
        run_req    = 1'($urandom_range(0, 1));
        // back in IDLE
        @(posedge clk); #1;
        step_req = 1'b0;
        run_req  = 1'b0;
    endtask

    // Monitor: accumulate enabled/busy cycles and check against the queue on done.
    initial begin : monitor
        int   en_cnt;
        int   busy_cnt;
        exp_t e;
        en_cnt = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_cnt = 0;
                busy_cnt = 0;
            end else begin
                if (cpu_en === 1'b1) en_cnt++;
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got done=1 expected no pending burst (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("enabled_cycles", 32'(en_cnt), 32'(e.en));
                        check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cyc));
                        check("stop_cause", {30'b0, stop_cause}, {30'b0, e.cause});
                        check("cycle_cnt", cycle_cnt, e.total);
                    end
                    en_cnt = 0;
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : driver
        bit          st;
        int          n, h, b;
        logic [31:0] a;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_stop_cause", {30'b0, stop_cause}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst_n = 1'b1;

        // directed bursts
        burst(1'b1, 3, -1, -1, 1'b0, 32'h0);
        burst(1'b1, 0, -1, -1, 1'b0, 32'h0);
        burst(1'b0, 10, -1, -1, 1'b0, 32'h0);
        burst(1'b0, 20, -1, 4, 1'b1, 32'h10);
        burst(1'b1, 1, -1, 0, 1'b1, 32'h10);
        burst(1'b1, 5, 1, -1, 1'b0, 32'h0);
        burst(1'b0, 6, 0, -1, 1'b1, 32'h40);

        // reset in the 3rd cycle of a step of 8
        @(posedge clk); #1;
        step_req = 1'b1; step_count = 16'd8; bp_en = 1'b0; halt_instr = 1'b0; pc = 32'h200;
        @(posedge clk); #1;
        step_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_cpu_en", {31'b0, cpu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
        exp_total = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        burst(1'b1, 2, -1, -1, 1'b0, 32'h0);

        // randomized bursts
        for (int k = 0; k < 40; k++) begin
            st = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 12));
            h  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n + 2)) : -1;
            b  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n + 2)) : -1;
            a  = $urandom;
            burst(st, n, h, b, 1'($urandom_range(0, 1)), a);
        end

        repeat (4) @(posedge clk);
        check("pending_bursts", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cpu_step_ctrl

`default_nettype wire
